// File: rtl/mips_seq_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS sequencing controller.
// Includes state encodings, opcode/funct codes, ALU control values and
// operand-2 select encodings.
package mips_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_EXCPT  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;

    // Funct field values for register-form instructions
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALU control values
    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_XOR  = 3'd7;

    // ALU operand-2 select
    localparam logic [1:0] SRC2_REG  = 2'd0;
    localparam logic [1:0] SRC2_SEXT = 2'd1;
    localparam logic [1:0] SRC2_ZEXT = 2'd2;

    // Destination select
    localparam logic RD_SEL_RD = 1'b0;
    localparam logic RD_SEL_RT = 1'b1;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct classifier.
// Anything outside the supported subset is reported as illegal, and in that
// case the controls are driven to neutral zeros.
module mips_ctrl_decode
    import mips_seq_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       legal,
    output logic       rd_src,
    output logic [1:0] alu_src2,
    output logic [2:0] alu_op
);

    // Classify the instruction word and derive its datapath controls
    always_comb begin
        legal    = 1'b0;
        rd_src   = RD_SEL_RD;
        alu_src2 = SRC2_REG;
        alu_op   = ALU_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin legal = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB: begin legal = 1'b1; alu_op = ALU_SUB; end
                    FN_AND: begin legal = 1'b1; alu_op = ALU_AND; end
                    FN_OR:  begin legal = 1'b1; alu_op = ALU_OR;  end
                    FN_XOR: begin legal = 1'b1; alu_op = ALU_XOR; end
                    FN_NOR: begin legal = 1'b1; alu_op = ALU_NOR; end
                    default: begin
                        legal  = 1'b0;
                        alu_op = ALU_NONE;
                    end
                endcase
            end
            OP_ADDI: begin
                legal    = 1'b1;
                rd_src   = RD_SEL_RT;
                alu_src2 = SRC2_SEXT;
                alu_op   = ALU_ADD;
            end
            OP_ANDI: begin
                legal    = 1'b1;
                rd_src   = RD_SEL_RT;
                alu_src2 = SRC2_ZEXT;
                alu_op   = ALU_AND;
            end
            OP_ORI: begin
                legal    = 1'b1;
                rd_src   = RD_SEL_RT;
                alu_src2 = SRC2_ZEXT;
                alu_op   = ALU_OR;
            end
            OP_XORI: begin
                legal    = 1'b1;
                rd_src   = RD_SEL_RT;
                alu_src2 = SRC2_ZEXT;
                alu_op   = ALU_XOR;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle sequencing controller: FETCH -> DECODE -> EXEC -> WB for legal
// instructions, and DECODE -> EXCPT -> HALT for unrecognised words.
// Every strobe except ir_load is a flop, loaded with the value that belongs
// to the state being entered. ir_load has to follow imem_ready within the
// same FETCH cycle, so it is gated from the registered fetch request.
module mips_seq_ctrl
    import mips_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        resume,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_en,
    output logic        rf_we,
    output logic        rd_src,
    output logic [1:0]  alu_src2,
    output logic [2:0]  alu_op,
    output logic        except,
    output logic        halted,
    output logic [15:0] instr_count
);

    state_t     state_r;
    logic       legal_s;
    logic       rd_src_s;
    logic [1:0] alu_src2_s;
    logic [2:0] alu_op_s;

    mips_ctrl_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .legal    (legal_s),
        .rd_src   (rd_src_s),
        .alu_src2 (alu_src2_s),
        .alu_op   (alu_op_s)
    );

    // imem_req is high exactly while in FETCH, so the capture lands in that state only
    assign ir_load = imem_req & imem_ready;

    // Sequencer state, registered strobes, latched decode controls and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_FETCH;
            imem_req    <= 1'b1;
            pc_en       <= 1'b0;
            rf_we       <= 1'b0;
            except      <= 1'b0;
            halted      <= 1'b0;
            rd_src      <= RD_SEL_RD;
            alu_src2    <= SRC2_REG;
            alu_op      <= ALU_NONE;
            instr_count <= 16'h0000;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_r  <= ST_DECODE;
                        imem_req <= 1'b0;
                    end else begin
                        state_r  <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    rd_src   <= rd_src_s;
                    alu_src2 <= alu_src2_s;
                    alu_op   <= alu_op_s;
                    if (legal_s) begin
                        state_r <= ST_EXEC;
                    end else begin
                        // Advance PC past the bad word while signalling the trap
                        state_r <= ST_EXCPT;
                        except  <= 1'b1;
                        pc_en   <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_WB;
                    rf_we   <= 1'b1;
                    pc_en   <= 1'b1;
                end
                ST_WB: begin
                    state_r     <= ST_FETCH;
                    rf_we       <= 1'b0;
                    pc_en       <= 1'b0;
                    imem_req    <= 1'b1;
                    instr_count <= instr_count + 16'd1;
                end
                ST_EXCPT: begin
                    state_r <= ST_HALT;
                    except  <= 1'b0;
                    pc_en   <= 1'b0;
                    halted  <= 1'b1;
                end
                ST_HALT: begin
                    if (resume) begin
                        state_r  <= ST_FETCH;
                        halted   <= 1'b0;
                        imem_req <= 1'b1;
                    end else begin
                        state_r  <= ST_HALT;
                        halted   <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encodings recover to a clean fetch
                    state_r  <= ST_FETCH;
                    imem_req <= 1'b1;
                    pc_en    <= 1'b0;
                    rf_we    <= 1'b0;
                    except   <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Self-checking bench for mips_seq_ctrl. An expected decode result is queued
// whenever an instruction word is presented. A negedge monitor pops one
// entry on every retire or exception pulse. Scenario tasks check sequencing
// and counter behaviour inline.
module tb_mips_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ready = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        resume = 1'b0;
    logic        imem_req;
    logic        ir_load;
    logic        pc_en;
    logic        rf_we;
    logic        rd_src;
    logic [1:0]  alu_src2;
    logic [2:0]  alu_op;
    logic        except;
    logic        halted;
    logic [15:0] instr_count;

    typedef struct packed {
        logic       legal;
        logic       rd_src;
        logic [1:0] src2;
        logic [2:0] aop;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_exp;
    exp_t        mon_obs;
    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] exp_cnt = 16'h0000;

    mips_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .imem_ready  (imem_ready),
        .opcode      (opcode),
        .funct       (funct),
        .resume      (resume),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .rf_we       (rf_we),
        .rd_src      (rd_src),
        .alu_src2    (alu_src2),
        .alu_op      (alu_op),
        .except      (except),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Reference decode table: {legal, rd_src, alu_src2, alu_op}
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn);
        exp_t e;
        e = 7'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: e = {1'b1, 1'b0, 2'd0, 3'd2};
                    6'h22: e = {1'b1, 1'b0, 2'd0, 3'd3};
                    6'h24: e = {1'b1, 1'b0, 2'd0, 3'd4};
                    6'h25: e = {1'b1, 1'b0, 2'd0, 3'd5};
                    6'h26: e = {1'b1, 1'b0, 2'd0, 3'd7};
                    6'h27: e = {1'b1, 1'b0, 2'd0, 3'd6};
                    default: e = 7'b0;
                endcase
            end
            6'h08: e = {1'b1, 1'b1, 2'd1, 3'd2};
            6'h0c: e = {1'b1, 1'b1, 2'd2, 3'd4};
            6'h0d: e = {1'b1, 1'b1, 2'd2, 3'd5};
            6'h0e: e = {1'b1, 1'b1, 2'd2, 3'd7};
            default: e = 7'b0;
        endcase
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every retire or exception consumes one queued expectation
    always @(negedge clk) begin
        if (rf_we === 1'b1 || except === 1'b1) begin
            compared++;
            if (rf_we === 1'b1 && except === 1'b1) begin
                mismatched++;
                $display("FAIL excl: rf_we=%b except=%b, required never both 1", rf_we, except);
            end
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL sb_empty: got rf_we=%b except=%b, required no pulse", rf_we, except);
            end else begin
                mon_exp = sb.pop_front();
                mon_obs = {rf_we, rd_src, alu_src2, alu_op};
                if (except === 1'b1) begin
                    if (mon_exp.legal !== 1'b0) begin
                        mismatched++;
                        $display("FAIL sb_except: got exception, required retire %h", mon_exp);
                    end
                end else if (mon_obs !== mon_exp) begin
                    mismatched++;
                    $display("FAIL sb_retire: got %h required %h", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1; imem_ready = 1'b0; resume = 1'b0; opcode = 6'h00; funct = 6'h00;
        tick; tick;
        compared++;
        if ({imem_req, ir_load, rf_we, pc_en, except, halted} !== 6'b100000) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b required 100000",
                     {imem_req, ir_load, rf_we, pc_en, except, halted});
        end
        compared++;
        if ({instr_count, rd_src, alu_src2, alu_op} !== 22'h0) begin
            mismatched++;
            $display("FAIL reset_regs: cnt=%h rd=%b s2=%0d op=%0d, required all 0",
                     instr_count, rd_src, alu_src2, alu_op);
        end
        reset = 1'b0;
        exp_cnt = 16'h0000;
    endtask

    task automatic test_add;
        logic [2:0] pat;
        logic       pc4;
        opcode = 6'h00; funct = 6'h20; imem_ready = 1'b1;
        sb.push_back(model(opcode, funct));
        #1;
        compared++;
        if (ir_load !== 1'b1) begin
            mismatched++; $display("FAIL add_irload: got %b required 1", ir_load);
        end
        tick; imem_ready = 1'b0;
        pat[0] = rf_we;
        tick; pat[1] = rf_we;
        tick; pat[2] = rf_we; pc4 = pc_en;
        tick;
        exp_cnt = exp_cnt + 16'd1;
        compared++;
        if (pat !== 3'b100 || pc4 !== 1'b1) begin
            mismatched++;
            $display("FAIL add_rfwe_cycle: got rf_we cyc4..2=%b pc_en=%b required 100/1", pat, pc4);
        end
        compared++;
        if ({alu_op, alu_src2, rd_src} !== {3'd2, 2'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL add_ctrl: got op=%0d s2=%0d rd=%b required 2/0/0", alu_op, alu_src2, rd_src);
        end
        compared++;
        if (instr_count !== 16'd1 || imem_req !== 1'b1) begin
            mismatched++;
            $display("FAIL add_count: got cnt=%h req=%b required 0001/1", instr_count, imem_req);
        end
    endtask

    task automatic test_xori_wait;
        int req_cyc;
        int rf_cnt;
        int req_after;
        req_cyc = 0; rf_cnt = 0; req_after = 0;
        opcode = 6'h0e; funct = 6'h00; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            req_cyc += int'(imem_req);
            tick;
        end
        imem_ready = 1'b1;
        sb.push_back(model(opcode, funct));
        #1;
        req_cyc += int'(imem_req);
        compared++;
        if (ir_load !== 1'b1) begin
            mismatched++; $display("FAIL xori_irload: got %b required 1", ir_load);
        end
        tick; imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rf_cnt += int'(rf_we);
            req_after += int'(imem_req);
            tick;
        end
        exp_cnt = exp_cnt + 16'd1;
        compared++;
        if (req_cyc != 4 || req_after != 0) begin
            mismatched++;
            $display("FAIL xori_req: got req cycles %0d (+%0d after), required 4 (+0)", req_cyc, req_after);
        end
        compared++;
        if (rf_cnt != 1) begin
            mismatched++; $display("FAIL xori_rfwe: got %0d pulses required 1", rf_cnt);
        end
        compared++;
        if ({alu_op, alu_src2, rd_src} !== {3'd7, 2'd2, 1'b1} || instr_count !== exp_cnt) begin
            mismatched++;
            $display("FAIL xori_ctrl: got op=%0d s2=%0d rd=%b cnt=%h required 7/2/1/%h",
                     alu_op, alu_src2, rd_src, instr_count, exp_cnt);
        end
    endtask

    task automatic test_illegal;
        opcode = 6'h00; funct = 6'h21; imem_ready = 1'b1;
        sb.push_back(model(opcode, funct));
        #1;
        tick; imem_ready = 1'b0;
        tick;
        compared++;
        if ({except, pc_en, rf_we} !== 3'b110) begin
            mismatched++;
            $display("FAIL ill_excpt: got except,pc_en,rf_we=%b required 110", {except, pc_en, rf_we});
        end
        imem_ready = 1'b1;
        tick;
        compared++;
        if ({halted, except, pc_en, rf_we, imem_req} !== 5'b10000) begin
            mismatched++;
            $display("FAIL ill_halt: got halted,except,pc_en,rf_we,req=%b required 10000",
                     {halted, except, pc_en, rf_we, imem_req});
        end
        tick; tick;
        compared++;
        if (halted !== 1'b1 || imem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL ill_stay: got halted=%b req=%b required 1/0", halted, imem_req);
        end
        imem_ready = 1'b0; resume = 1'b1;
        tick;
        resume = 1'b0;
        compared++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || instr_count !== exp_cnt) begin
            mismatched++;
            $display("FAIL ill_resume: got halted=%b req=%b cnt=%h required 0/1/%h",
                     halted, imem_req, instr_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] ops [8];
        logic [5:0] fns [8];
        ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d};
        fns = '{6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h11, 6'h3f, 6'h20};
        imem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            opcode = ops[i]; funct = fns[i];
            sb.push_back(model(opcode, funct));
            #1;
            compared++;
            if (ir_load !== 1'b1) begin
                mismatched++; $display("FAIL b2b_irload[%0d]: got %b required 1", i, ir_load);
            end
            tick;
            tick;
            // Controls must hold their decoded values even if the IR fields change
            opcode = 6'h3f; funct = 6'h3f;
            tick;
            compared++;
            if (rf_we !== 1'b1) begin
                mismatched++; $display("FAIL b2b_wb[%0d]: got rf_we=%b required 1", i, rf_we);
            end
            tick;
            exp_cnt = exp_cnt + 16'd1;
        end
        imem_ready = 1'b0;
        compared++;
        if (instr_count !== exp_cnt) begin
            mismatched++; $display("FAIL b2b_count: got %h required %h", instr_count, exp_cnt);
        end
    endtask

    task automatic test_reset_in_wb;
        opcode = 6'h00; funct = 6'h20; imem_ready = 1'b1;
        sb.push_back(model(opcode, funct));
        #1;
        tick; imem_ready = 1'b0;
        tick; resume = 1'b1;
        tick; resume = 1'b0;
        compared++;
        if ({rf_we, halted, imem_req} !== 3'b100) begin
            mismatched++;
            $display("FAIL wb_resume_ignored: got rf_we,halted,req=%b required 100", {rf_we, halted, imem_req});
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_cnt = 16'h0000;
        compared++;
        if ({imem_req, rf_we, pc_en, halted} !== 4'b1000 || instr_count !== 16'h0000 || alu_op !== 3'd0) begin
            mismatched++;
            $display("FAIL wb_reset: got req,rf_we,pc_en,halted=%b cnt=%h op=%0d required 1000/0000/0",
                     {imem_req, rf_we, pc_en, halted}, instr_count, alu_op);
        end
    endtask

    task automatic test_wrap;
        opcode = 6'h08; funct = 6'h00; imem_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            sb.push_back(model(opcode, funct));
            tick; tick; tick; tick;
        end
        compared++;
        if (instr_count !== 16'hFFFF) begin
            mismatched++; $display("FAIL wrap_preload: got %h required ffff", instr_count);
        end
        sb.push_back(model(opcode, funct));
        tick; tick; tick; tick;
        imem_ready = 1'b0;
        compared++;
        if (instr_count !== 16'h0000) begin
            mismatched++; $display("FAIL wrap_zero: got %h required 0000", instr_count);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_xori_wait();
        test_illegal();
        test_back_to_back();
        test_reset_in_wb();
        test_wrap();
        tick;
        compared++;
        if (sb.size() != 0) begin
            mismatched++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
